// File: rtl/rx_data_capture.sv
// UART Rx data path: assembles LSB-first bytes, checks parity/stop, and holds the
// result in a one-entry valid/ready buffer. Define RX_MAJORITY_VOTE_EN for 3-sample glitch rejection.
module rx_data_capture #(
  parameter bit PARITY_ODD = 1'b0,
  parameter int DATA_BITS  = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       serial_in,
  input  logic       sampling_strobe,
  input  logic       data_is_available,
  input  logic       is_parity_stage,
  input  logic       data_is_valid,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       parity_error,
  output logic       framing_error,
  output logic       overrun,
  input  logic       clear_overrun
);

  localparam logic [3:0] FRAME_BITS = 4'(DATA_BITS);

  logic [7:0] r_shiftReg;
  logic [3:0] r_bitCnt;
  logic       r_parBit;

  logic       w_sample;
  logic       w_stopStrobe;
  logic       w_parityStrobe;
  logic       w_dataStrobe;
  logic       w_idleStrobe;
  logic       w_framePerr;
  logic       w_frameFerr;
  logic       w_canLoad;

`ifdef RX_MAJORITY_VOTE_EN
  logic [2:0] r_history;

  // History resets to all ones so an idle line never looks like a start glitch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_history <= 3'b111;
    end else begin
      r_history <= {r_history[1:0], serial_in};
    end
  end

  assign w_sample = (r_history[0] & r_history[1]) |
                    (r_history[1] & r_history[2]) |
                    (r_history[0] & r_history[2]);
`else
  assign w_sample = serial_in;
`endif

  // Overlapping stage flags are resolved stop > parity > data.
  assign w_stopStrobe   = sampling_strobe & data_is_valid;
  assign w_parityStrobe = sampling_strobe & is_parity_stage & ~data_is_valid;
  assign w_dataStrobe   = sampling_strobe & data_is_available & ~is_parity_stage & ~data_is_valid;
  assign w_idleStrobe   = sampling_strobe & ~data_is_available & ~is_parity_stage & ~data_is_valid;

  assign w_framePerr = (^r_shiftReg) ^ r_parBit ^ PARITY_ODD;
  assign w_frameFerr = ~w_sample | (r_bitCnt != FRAME_BITS);
  assign w_canLoad   = ~rx_valid | rx_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shiftReg <= 8'h00;
      r_bitCnt   <= 4'd0;
      r_parBit   <= 1'b0;
    end else begin
      if (w_dataStrobe) begin
        r_shiftReg <= {w_sample, r_shiftReg[7:1]};
        if (r_bitCnt != 4'hF) begin
          r_bitCnt <= r_bitCnt + 4'd1;
        end
      end
      if (w_parityStrobe) begin
        r_parBit <= w_sample;
      end
      if (w_stopStrobe || w_idleStrobe) begin
        r_bitCnt <= 4'd0;
      end
    end
  end

  // A commit that finds the buffer full and not being drained is dropped and flagged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_data       <= 8'h00;
      rx_valid      <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      if (w_stopStrobe && w_canLoad) begin
        rx_data       <= r_shiftReg;
        parity_error  <= w_framePerr;
        framing_error <= w_frameFerr;
        rx_valid      <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      if (w_stopStrobe && !w_canLoad) begin
        overrun <= 1'b1;
      end else if (clear_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rx_data_capture.sv
// Scoreboard bench for rx_data_capture: even- and odd-parity instances share stimulus,
// a negedge monitor pops expected frames whenever a new frame is presented.
module tb_rx_data_capture;

  typedef struct {
    logic [7:0] data;
    logic       perrEven;
    logic       perrOdd;
    logic       ferr;
  } expT;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       serial_in = 1'b1;
  logic       sampling_strobe = 1'b0;
  logic       data_is_available = 1'b0;
  logic       is_parity_stage = 1'b0;
  logic       data_is_valid = 1'b0;
  logic       rx_ready = 1'b0;
  logic       clear_overrun = 1'b0;

  logic [7:0] rx_data, oddData;
  logic       rx_valid, parity_error, framing_error, overrun;
  logic       oddValid, oddPerr, oddFerr, oddOverrun;

  expT        expQ[$];
  int         errCount = 0;
  int         checkCount = 0;
  logic       prevValid = 1'b0;
  logic       prevReady = 1'b0;

  rx_data_capture #(.PARITY_ODD(1'b0), .DATA_BITS(8)) u_even (
    .clk(clk), .reset_n(reset_n), .serial_in(serial_in),
    .sampling_strobe(sampling_strobe), .data_is_available(data_is_available),
    .is_parity_stage(is_parity_stage), .data_is_valid(data_is_valid),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .parity_error(parity_error), .framing_error(framing_error),
    .overrun(overrun), .clear_overrun(clear_overrun)
  );

  rx_data_capture #(.PARITY_ODD(1'b1), .DATA_BITS(8)) u_odd (
    .clk(clk), .reset_n(reset_n), .serial_in(serial_in),
    .sampling_strobe(sampling_strobe), .data_is_available(data_is_available),
    .is_parity_stage(is_parity_stage), .data_is_valid(data_is_valid),
    .rx_data(oddData), .rx_valid(oddValid), .rx_ready(rx_ready),
    .parity_error(oddPerr), .framing_error(oddFerr),
    .overrun(oddOverrun), .clear_overrun(clear_overrun)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // A new frame is on the outputs when valid rises or stays high across a handshake.
  always @(negedge clk) begin
    if (rx_valid && (!prevValid || prevReady)) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedFrame", 32'(rx_data), 32'hFFFF_FFFF);
      end else begin
        expT e;
        e = expQ.pop_front();
        checkOutput("rxData", 32'(rx_data), 32'(e.data));
        checkOutput("parityErrEven", 32'(parity_error), 32'(e.perrEven));
        checkOutput("parityErrOdd", 32'(oddPerr), 32'(e.perrOdd));
        checkOutput("framingErr", 32'(framing_error), 32'(e.ferr));
      end
    end
    prevValid = rx_valid;
    prevReady = rx_ready;
  end

  // stage: 0 = start (no flag), 1 = data, 2 = parity, 3 = stop
  task automatic sendBit(input int stage, input logic b, input bit glitch, input bit readyAtStrobe);
    serial_in         = b;
    data_is_available = (stage == 1);
    is_parity_stage   = (stage == 2);
    data_is_valid     = (stage == 3);
    repeat (3) begin
      @(posedge clk); #1;
    end
    sampling_strobe = 1'b1;
    if (glitch) serial_in = 1'b0;
    if (readyAtStrobe) rx_ready = 1'b1;
    @(posedge clk); #1;
    sampling_strobe = 1'b0;
    serial_in       = b;
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic par, input logic stop,
                               input int nData, input bit readyAtStop, input int glitchBit,
                               input bit present, input logic [7:0] expData,
                               input logic expPe, input logic expPo, input logic expFe);
    expT e;
    if (present) begin
      e.data = expData; e.perrEven = expPe; e.perrOdd = expPo; e.ferr = expFe;
      expQ.push_back(e);
    end
    sendBit(0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < nData; i++) sendBit(1, d[i], (glitchBit == i), 1'b0);
    sendBit(2, par, 1'b0, 1'b0);
    sendBit(3, stop, 1'b0, readyAtStop);
    data_is_valid = 1'b0;
    serial_in     = 1'b1;
  endtask

  task automatic consume();
    rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #2;
    checkOutput("resetValid", 32'(rx_valid), 32'd0);
    checkOutput("resetData", 32'(rx_data), 32'd0);
    checkOutput("resetOverrun", 32'(overrun), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // 0xA5 has four ones: even parity bit 0 is clean, odd build flags it.
    applyStimulus(8'hA5, 1'b0, 1'b1, 8, 1'b0, -1, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("validAfterStop", 32'(rx_valid), 32'd1);
    consume();
    applyStimulus(8'hA5, 1'b1, 1'b1, 8, 1'b0, -1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
    consume();
    applyStimulus(8'h3C, 1'b0, 1'b0, 8, 1'b0, -1, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b1);
    consume();
    // Seven ones shifted over 0x3C leave 0xFE; parity bit 1 makes eight ones.
    applyStimulus(8'hFF, 1'b1, 1'b1, 7, 1'b0, -1, 1'b1, 8'hFE, 1'b0, 1'b1, 1'b1);
    consume();

    applyStimulus(8'h11, 1'b0, 1'b1, 8, 1'b0, -1, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'h22, 1'b0, 1'b1, 8, 1'b0, -1, 1'b0, 8'h22, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("heldAfterDrop", 32'(rx_data), 32'h11);
    checkOutput("overrunSet", 32'(overrun), 32'd1);
    checkOutput("validHeld", 32'(rx_valid), 32'd1);
    @(posedge clk); #1 clear_overrun = 1'b1;
    @(posedge clk); #1 clear_overrun = 1'b0;
    checkOutput("overrunCleared", 32'(overrun), 32'd0);
    consume();
    @(negedge clk);
    checkOutput("validDropped", 32'(rx_valid), 32'd0);

    applyStimulus(8'h11, 1'b0, 1'b1, 8, 1'b0, -1, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'h22, 1'b0, 1'b1, 8, 1'b1, -1, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("backToBackValid", 32'(rx_valid), 32'd1);
    checkOutput("backToBackOverrun", 32'(overrun), 32'd0);
    @(posedge clk); #1 rx_ready = 1'b0;

    applyStimulus(8'h33, 1'b1, 1'b0, 8, 1'b0, -1, 1'b1, 8'h33, 1'b1, 1'b0, 1'b1);
    applyStimulus(8'h44, 1'b0, 1'b1, 8, 1'b0, -1, 1'b0, 8'h44, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("overrunBeforeReset", 32'(overrun), 32'd1);
    sendBit(0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) sendBit(1, (i % 2 == 1), 1'b0, 1'b0);
    reset_n = 1'b0;
    #2;
    checkOutput("midResetValid", 32'(rx_valid), 32'd0);
    checkOutput("midResetData", 32'(rx_data), 32'd0);
    checkOutput("midResetPerr", 32'(parity_error), 32'd0);
    checkOutput("midResetFerr", 32'(framing_error), 32'd0);
    checkOutput("midResetOverrun", 32'(overrun), 32'd0);
    data_is_available = 1'b0;
    serial_in         = 1'b1;
    @(posedge clk); #1 reset_n = 1'b1;
    applyStimulus(8'h5A, 1'b0, 1'b1, 8, 1'b0, -1, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b0);
    consume();

`ifdef RX_MAJORITY_VOTE_EN
    applyStimulus(8'hFF, 1'b0, 1'b1, 8, 1'b0, 3, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0);
    consume();
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/rx_data_capture.md
Name: rx_data_capture

Overview:
- Downstream consumer of the UART Rx state machine.
- Samples the serial line on each sampling strobe, steered by the FSM's stage flags (data_is_available, is_parity_stage, data_is_valid).
- Assembles the 8-bit LSB-first byte, checks parity and the stop bit, and presents the result through a one-entry valid/ready output buffer with overrun detection.

Parameters:
- PARITY_ODD, 0, parity sense: 0 = even (data plus parity bit has an even count of 1s), 1 = odd.
- DATA_BITS, 8, data bits per frame; fixed at 8, and the bit counter is 4 bits wide.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- serial_in  input  1  Rx line, already synchronised to clk.
- sampling_strobe  input  1  one-clk pulse at bit centre, same strobe the FSM uses; pulses are at least 2 clk apart.
- data_is_available  input  1  FSM flag: currently in a data bit stage.
- is_parity_stage  input  1  FSM flag: currently in the parity stage.
- data_is_valid  input  1  FSM flag: currently in the stop stage.
- rx_data  output  8  received byte.
- rx_valid  output  1  rx_data, parity_error and framing_error hold a frame.
- rx_ready  input  1  consumer accepts the frame when rx_valid and rx_ready are both 1 on a clk edge.
- parity_error  output  1  parity mismatch for the held frame.
- framing_error  output  1  stop bit low, or bit count not equal to 8, for the held frame.
- overrun  output  1  sticky; a completed frame was dropped.
- clear_overrun  input  1  synchronous clear of overrun.

Behaviour:
- Reset (reset_n=0, asynchronous): every output drives 0.
  - Internal state is also cleared: shift_reg=0, bit_cnt=0, par_bit=0.
- Sample value s = serial_in at the strobe clk (see the optional feature below).
- Strobe in a data stage (sampling_strobe && data_is_available):
  - shift_reg <= {s, shift_reg[7:1]}, i.e. LSB first.
  - bit_cnt <= bit_cnt+1, saturating at 15.
- Strobe in the parity stage (sampling_strobe && is_parity_stage): par_bit <= s.
- Strobe in the stop stage (sampling_strobe && data_is_valid): commit.
  - frame_perr = (^shift_reg) ^ par_bit ^ PARITY_ODD.
  - frame_ferr = (s==0) || (bit_cnt!=8).
  - bit_cnt <= 0 in the same cycle.
- Strobe with no flag set (FSM idle or start stage): bit_cnt <= 0, which discards partial frames; shift_reg is left unchanged.
- More than one flag set on a strobe is illegal input. Priority is stop > parity > data.
- Commit into the output buffer; all outputs are registered, and rx_valid rises 1 clk after the stop strobe:
  - Buffer empty (rx_valid=0): load rx_data, parity_error and framing_error; rx_valid <= 1.
  - rx_valid=1 and rx_ready=1 in the same cycle: the old frame is consumed and the new one is loaded; rx_valid stays 1; no overrun.
  - rx_valid=1 and rx_ready=0: the new frame is dropped, the held frame is unchanged, and overrun <= 1.
- Handshake:
  - rx_valid=1 and rx_ready=1 with no commit: rx_valid <= 0; rx_data and the error flags hold their last value.
  - Held outputs are stable while rx_valid=1 and rx_ready=0.
- overrun:
  - Set by a dropped commit; cleared by clear_overrun.
  - If set and clear happen in the same cycle, set wins.
- Reset mid-frame: returns to the reset state immediately; the next frame is captured normally once the FSM restarts.

Optional Feature:
- Macro: RX_MAJORITY_VOTE_EN.
- Defined:
  - A 3-bit history register shifts in serial_in every clk and resets to 3'b111 (line idle).
  - s = majority of the 3 history bits at the strobe clk.
  - Adds glitch rejection; capture timing is unchanged relative to the strobe.
- Undefined: s = serial_in sampled directly; no history register.

Test Plan:
- Even parity (PARITY_ODD=0), byte 0xA5, parity bit 0, stop bit 1 -> rx_valid=1 one clk after the stop strobe; rx_data=0xA5; parity_error=0; framing_error=0.
- Same frame with parity bit 1 -> rx_data=0xA5, parity_error=1. With PARITY_ODD=1 and parity bit 1 -> parity_error=0.
- Byte 0x3C with stop bit sampled 0 -> framing_error=1, rx_data=0x3C. A frame with only 7 data strobes -> framing_error=1.
- Two frames, 0x11 then 0x22, with rx_ready held 0 -> rx_data stays 0x11 and overrun=1. Then clear_overrun=1 -> overrun=0. Then rx_ready=1 for one clk -> rx_valid=0.
- Back-to-back commit with rx_ready=1 in the same cycle as the second stop strobe's commit -> rx_data=0x22, rx_valid stays 1, overrun=0.
- reset_n pulsed low after 4 data bits, then a full 0x5A frame -> all outputs 0 during reset; 0x5A is received clean.
- With RX_MAJORITY_VOTE_EN defined: a single-clk low glitch on serial_in at a strobe during a 1 bit -> the bit is captured as 1.
